// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle event pulses into fixed-length high windows
// separated by a forced low gap. Events arriving mid-window are either queued
// (each becomes its own later window) or retrigger the current window.
//
// Handshake: there is no valid/ready pair. i_Pulse is sampled on every
// posedge and each high sample is one event; nothing is ever back-pressured.
// Events that find the queue full are dropped and flagged on o_Overflow.
module pulse_stretch #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int QUEUE_MAX   = 3,
    parameter int RETRIGGER   = 0
) (
    input  logic                             i_Clk,
    input  logic                             i_Rst,
    input  logic                             i_Pulse,
    input  logic                             i_Clear,
    output logic                             o_Data,
    output logic                             o_Busy,
    output logic [$clog2(QUEUE_MAX+1)-1:0]   o_Pending,
    output logic                             o_Overflow,
    output logic [1:0]                       o_State
);

    localparam int PW      = $clog2(QUEUE_MAX + 1);
    localparam int CNT_MAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(QUEUE_MAX);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_pend;
    logic          r_ovf;
    logic          r_data;
    logic          r_busy;

    logic [1:0]    w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [PW-1:0] w_pend_base;
    logic [PW-1:0] w_pend_nx;
    logic          w_ovf_nx;
    logic          w_enq;
    logic          w_deq;

    // Next-state, shared down-counter and pending-queue arithmetic. A clear is
    // applied first, so the window decision and any same-cycle event see the
    // emptied queue.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_pend_base = i_Clear ? '0 : r_pend;
        w_ovf_nx    = i_Clear ? 1'b0 : r_ovf;
        w_enq       = 1'b0;
        w_deq       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_Pulse) begin
                    w_state_nx = S_HIGH;
                    w_cnt_nx   = HIGH_LOAD;
                end
            end
            S_HIGH: begin
                if (i_Pulse && (RETRIGGER != 0)) begin
                    // Reload wins even over the exit on the last high cycle.
                    w_cnt_nx = HIGH_LOAD;
                end else begin
                    if (i_Pulse) begin
                        w_enq = 1'b1;
                    end
                    if (r_cnt == '0) begin
                        w_state_nx = S_GAP;
                        w_cnt_nx   = GAP_LOAD;
                    end else begin
                        w_cnt_nx = r_cnt - 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                    if (i_Pulse) begin
                        w_enq = 1'b1;
                    end
                end else if (w_pend_base != '0) begin
                    // Start the next queued window with no idle cycle between.
                    w_state_nx = S_HIGH;
                    w_cnt_nx   = HIGH_LOAD;
                    w_deq      = 1'b1;
                    if (i_Pulse) begin
                        w_enq = 1'b1;
                    end
                end else if (i_Pulse) begin
                    // Empty queue: the event starts the next window directly.
                    w_state_nx = S_HIGH;
                    w_cnt_nx   = HIGH_LOAD;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase

        // Saturating queue; a simultaneous enqueue and dequeue cancel out.
        w_pend_nx = w_pend_base;
        if (w_enq && !w_deq) begin
            if (w_pend_base == PEND_MAX) begin
                w_ovf_nx = 1'b1;
            end else begin
                w_pend_nx = w_pend_base + 1'b1;
            end
        end else if (w_deq && !w_enq) begin
            w_pend_nx = w_pend_base - 1'b1;
        end
    end

    // State, counter, queue and registered outputs; reset aborts everything.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_data  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_pend  <= w_pend_nx;
            r_ovf   <= w_ovf_nx;
            r_data  <= (w_state_nx == S_HIGH);
            r_busy  <= (w_state_nx != S_IDLE);
        end
    end

    assign o_Data     = r_data;
    assign o_Busy     = r_busy;
    assign o_Pending  = r_pend;
    assign o_Overflow = r_ovf;
    assign o_State    = r_state;

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: drives a queueing and a retriggering pulse_stretch with the
// same stimulus and compares both against a timestamp-based window model.
module tb_pulse_stretch;

    localparam int H = 4;
    localparam int G = 2;
    localparam int Q = 3;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       pulse = 1'b0;
    logic       clear = 1'b0;
    logic       d0, b0, o0, d1, b1, o1;
    logic [1:0] p0, p1, s0, s1;

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    // Model: a window is described by the edge at which its high part ends
    // (hi_exit); the gap ends at hi_exit+G. Index 0 queues, index 1 retriggers.
    int m_active  [2];
    int m_hi_exit [2];
    int m_pend    [2];
    int m_ovf     [2];

    always #5 clk = ~clk;

    pulse_stretch #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .QUEUE_MAX(Q), .RETRIGGER(0)) u_queue (
        .i_Clk(clk), .i_Rst(rst), .i_Pulse(pulse), .i_Clear(clear),
        .o_Data(d0), .o_Busy(b0), .o_Pending(p0), .o_Overflow(o0), .o_State(s0)
    );

    pulse_stretch #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .QUEUE_MAX(Q), .RETRIGGER(1)) u_retrig (
        .i_Clk(clk), .i_Rst(rst), .i_Pulse(pulse), .i_Clear(clear),
        .o_Data(d1), .o_Busy(b1), .o_Pending(p1), .o_Overflow(o1), .o_State(s1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_active[k]  = 0;
            m_hi_exit[k] = 0;
            m_pend[k]    = 0;
            m_ovf[k]     = 0;
        end
    endtask

    task automatic model_edge(input int k, input logic p, input logic c);
        int pend;
        int ovf;
        pend = c ? 0 : m_pend[k];
        ovf  = c ? 0 : m_ovf[k];
        if (m_active[k] == 0) begin
            if (p) begin
                m_active[k]  = 1;
                m_hi_exit[k] = t + H;
            end
        end else if (t <= m_hi_exit[k]) begin
            if (p) begin
                if (k == 1) m_hi_exit[k] = t + H;
                else if (pend < Q) pend++;
                else ovf = 1;
            end
        end else if (t == m_hi_exit[k] + G) begin
            if (pend > 0) begin
                m_hi_exit[k] = t + H;
                if (!p) pend--;
            end else if (p) begin
                m_hi_exit[k] = t + H;
            end else begin
                m_active[k] = 0;
            end
        end else if (p) begin
            if (pend < Q) pend++;
            else ovf = 1;
        end
        m_pend[k] = pend;
        m_ovf[k]  = ovf;
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            int exp_data;
            exp_data = (m_active[k] != 0 && t < m_hi_exit[k]) ? 1 : 0;
            check($sformatf("%s.u%0d.data", tag, k), int'(k == 0 ? d0 : d1), exp_data);
            check($sformatf("%s.u%0d.busy", tag, k), int'(k == 0 ? b0 : b1), m_active[k]);
            check($sformatf("%s.u%0d.state_busy", tag, k),
                  int'((k == 0 ? s0 : s1) != 2'd0), m_active[k]);
            check($sformatf("%s.u%0d.pending", tag, k), int'(k == 0 ? p0 : p1), m_pend[k]);
            check($sformatf("%s.u%0d.overflow", tag, k), int'(k == 0 ? o0 : o1), m_ovf[k]);
        end
    endtask

    // One clock edge: drive inputs, advance model, sample 1 time unit later.
    task automatic step(input logic p, input logic c);
        pulse = p;
        clear = c;
        @(posedge clk);
        t++;
        model_edge(0, p, c);
        model_edge(1, p, c);
        #1;
        compare_all("step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Reset pulse placed between two edges; outputs must clear with no clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        check("async_rst.data", int'(d0), 0);
        check("async_rst.pending", int'(p0), 0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int density;
        model_reset();
        #1 rst = 1'b1;
        #1;
        compare_all("reset");
        check("reset.busy", int'(b0), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single pulse: high for H edges, busy for H+G.
        idle(3);
        step(1'b1, 1'b0);
        check("single.first_high", int'(d0), 1);
        idle(3);
        check("single.last_high", int'(d0), 1);
        idle(1);
        check("single.low", int'(d0), 0);
        idle(1);
        check("single.gap_busy", int'(b0), 1);
        idle(1);
        check("single.idle", int'(b0), 0);

        // Four back-to-back pulses: three queued windows.
        idle(3);
        repeat (4) step(1'b1, 1'b0);
        check("queue.full", int'(p0), 3);
        check("queue.no_ovf", int'(o0), 0);
        idle(24);
        check("queue.drained", int'(p0), 0);

        // Held pulse overflows the queue; clear mid-window empties it.
        idle(3);
        repeat (6) step(1'b1, 1'b0);
        check("ovf.set", int'(o0), 1);
        check("ovf.sat", int'(p0), 3);
        idle(4);
        step(1'b0, 1'b1);
        check("clear.pending", int'(p0), 0);
        check("clear.ovf", int'(o0), 0);
        check("clear.busy", int'(b0), 1);
        idle(12);

        // Retrigger: pulses two edges apart give one extended window.
        step(1'b1, 1'b0);
        idle(1);
        step(1'b1, 1'b0);
        idle(3);
        check("retrig.high", int'(d1), 1);
        idle(1);
        check("retrig.low", int'(d1), 0);
        check("retrig.pending", int'(p1), 0);
        idle(8);

        // Pulse on the final gap edge with an empty queue restarts directly.
        step(1'b1, 1'b0);
        idle(5);
        step(1'b1, 1'b0);
        check("gap_end.high", int'(d0), 1);
        check("gap_end.pending", int'(p0), 0);
        idle(10);

        // Reset in the middle of a window with two queued events.
        repeat (3) step(1'b1, 1'b0);
        check("rst_mid.pending", int'(p0), 2);
        async_reset();
        step(1'b1, 1'b0);
        check("rst_after.high", int'(d0), 1);
        idle(3);
        check("rst_after.still_high", int'(d0), 1);
        idle(1);
        check("rst_after.low", int'(d0), 0);
        idle(4);

        // Randomized traffic with varying density, clears and resets.
        density = 40;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) density = $urandom_range(5, 80);
            step(($urandom_range(0, 99) < density) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
